// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue path: opcode values, 5-bit ALU mode codes
// and the issue-buffer state encoding.
package alu_issue_pkg;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'h00,
    ALU_LLS  = 5'h01,
    ALU_SSLT = 5'h02,
    ALU_USLT = 5'h03,
    ALU_XOR  = 5'h04,
    ALU_LRS  = 5'h05,
    ALU_OR   = 5'h06,
    ALU_AND  = 5'h07,
    ALU_SUB  = 5'h10,
    ALU_ARS  = 5'h15
  } alu_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } issue_state_e;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RISC-V OP / OP-IMM decoder producing the 5-bit ALU mode,
// the illegal flag and the immediate-operand select.
module alu_decode
  import alu_issue_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [4:0] alu_mode,
  output logic       illegal,
  output logic       use_imm
);

  always_comb begin
    alu_mode = ALU_ADD;
    illegal  = 1'b1;
    use_imm  = 1'b0;
    case (opcode)
      OPC_OP: begin
        illegal  = funct7_5 && !((funct3 == 3'd0) || (funct3 == 3'd5));
        alu_mode = {funct7_5, 1'b0, funct3};
      end
      OPC_OP_IMM: begin
        illegal  = funct7_5 && (funct3 == 3'd1);
        use_imm  = 1'b1;
        // bit 30 only selects SRAI among immediates; elsewhere it is imm data
        alu_mode = {funct7_5 && (funct3 == 3'd5), 1'b0, funct3};
      end
      default: ;
    endcase
    if (illegal) alu_mode = ALU_ADD;
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes an instruction and hands operands to the ALU through
// a 2-entry skid buffer (main + skid) with registered upstream ready.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned WordSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7_5,
  input  logic [WordSize-1:0] rs1_data,
  input  logic [WordSize-1:0] rs2_data,
  input  logic [WordSize-1:0] imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WordSize-1:0] a,
  output logic [WordSize-1:0] b,
  output logic [15:0]         alu_mode,
  output logic                illegal
);

  issue_state_e r_state, w_state_nxt;

  logic [WordSize-1:0] r_main_a, r_main_b, r_skid_a, r_skid_b;
  logic [4:0]          r_main_mode, r_skid_mode;
  logic                r_main_ill, r_skid_ill;

  logic [4:0]          w_dec_mode;
  logic                w_dec_ill, w_dec_imm;
  logic [WordSize-1:0] w_in_a, w_in_b;
  logic                w_in_xfer, w_out_xfer;
  logic                w_ld_main, w_ld_skid, w_mv_skid;

  alu_decode u_decode (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_mode (w_dec_mode),
    .illegal  (w_dec_ill),
    .use_imm  (w_dec_imm)
  );

  assign w_in_a = w_dec_ill ? '0 : rs1_data;
  assign w_in_b = w_dec_ill ? '0 : (w_dec_imm ? imm : rs2_data);

  assign in_ready   = (r_state != ST_FULL);
  assign out_valid  = (r_state != ST_EMPTY);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_main   = 1'b0;
    w_ld_skid   = 1'b0;
    w_mv_skid   = 1'b0;
    case (r_state)
      ST_EMPTY: if (w_in_xfer) begin
        w_state_nxt = ST_BUSY;
        w_ld_main   = 1'b1;
      end
      ST_BUSY: begin
        if (w_in_xfer && w_out_xfer) begin
          w_ld_main = 1'b1;
        end else if (w_in_xfer) begin
          w_state_nxt = ST_FULL;
          w_ld_skid   = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: if (w_out_xfer) begin
        w_state_nxt = ST_BUSY;
        w_mv_skid   = 1'b1;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_ld_main   = 1'b0;
      w_ld_skid   = 1'b0;
      w_mv_skid   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_main_a    <= '0;
      r_main_b    <= '0;
      r_main_mode <= '0;
      r_main_ill  <= 1'b0;
      r_skid_a    <= '0;
      r_skid_b    <= '0;
      r_skid_mode <= '0;
      r_skid_ill  <= 1'b0;
    end else begin
      if (w_ld_main) begin
        r_main_a    <= w_in_a;
        r_main_b    <= w_in_b;
        r_main_mode <= w_dec_mode;
        r_main_ill  <= w_dec_ill;
      end else if (w_mv_skid) begin
        r_main_a    <= r_skid_a;
        r_main_b    <= r_skid_b;
        r_main_mode <= r_skid_mode;
        r_main_ill  <= r_skid_ill;
      end
      if (w_ld_skid) begin
        r_skid_a    <= w_in_a;
        r_skid_b    <= w_in_b;
        r_skid_mode <= w_dec_mode;
        r_skid_ill  <= w_dec_ill;
      end
    end
  end

  // main keeps stale data once drained, so the outputs are gated by occupancy
  assign a        = out_valid ? r_main_a : '0;
  assign b        = out_valid ? r_main_b : '0;
  assign alu_mode = out_valid ? {11'd0, r_main_mode} : '0;
  assign illegal  = out_valid ? r_main_ill : 1'b0;

endmodule
